// File: rtl/retro_bram_arbiter.sv
// Round-robin arbiter sharing one single-port RetroBRAM among several
// initiators, with tagged read return and a timeout-bounded access lock.
module retro_bram_arbiter #(
    parameter int Requesters      = 3,
    parameter int AddressBusWidth = 12,
    parameter int DataBusWidth    = 1,
    parameter int LockTimeout     = 16
) (
    input  logic                                    Clk,
    input  logic                                    Reset_n,
    input  logic [Requesters-1:0]                   ReqAccess,
    input  logic [Requesters-1:0]                   ReqWrite,
    input  logic [Requesters-1:0]                   ReqLock,
    input  logic [Requesters*AddressBusWidth-1:0]   ReqAddress,
    input  logic [Requesters*DataBusWidth-1:0]      ReqMask,
    input  logic [Requesters*8*DataBusWidth-1:0]    ReqDToTarget,
    output logic [Requesters-1:0]                   ReqReady,
    output logic [Requesters-1:0]                   ReqDataReady,
    output logic [8*DataBusWidth-1:0]               ReqDToInitiator,
    output logic                                    MemAccess,
    output logic                                    MemWrite,
    output logic [AddressBusWidth-1:0]              MemAddress,
    output logic [DataBusWidth-1:0]                 MemMask,
    output logic [8*DataBusWidth-1:0]               MemDToTarget,
    input  logic [8*DataBusWidth-1:0]               MemDToInitiator,
    input  logic                                    MemReady
);

    localparam int PW = $clog2(Requesters);
    localparam int CW = $clog2(LockTimeout + 1);
    localparam int DW = 8 * DataBusWidth;
    localparam int AW = AddressBusWidth;
    localparam int BW = DataBusWidth;

    logic [PW-1:0]         r_last;
    logic [PW-1:0]         r_owner;
    logic [PW-1:0]         r_rd_owner;
    logic                  r_rd_valid;
    logic                  r_locked;
    logic [CW-1:0]         r_idle;

    logic                  w_timeout;
    logic [Requesters-1:0] w_elig;
    logic                  w_hit;
    logic [PW-1:0]         w_win;
    logic                  w_accept;
    int                    w_idx;

    assign w_timeout = r_locked && (r_idle == CW'(LockTimeout));

    // A timed-out lock still favours its owner if it asks in that very cycle.
    always_comb begin
        w_elig = ReqAccess;
        if (r_locked && !(w_timeout && !ReqAccess[r_owner])) begin
            w_elig = '0;
            w_elig[r_owner] = ReqAccess[r_owner];
        end
    end

    // Scan from farthest to nearest so the nearest eligible requester sticks.
    always_comb begin
        w_hit = 1'b0;
        w_win = '0;
        w_idx = 0;
        for (int k = Requesters; k >= 1; k--) begin
            w_idx = (int'(r_last) + k) % Requesters;
            if (w_elig[w_idx]) begin
                w_hit = 1'b1;
                w_win = PW'(w_idx);
            end
        end
    end

    assign w_accept = Reset_n && w_hit && MemReady;

    assign ReqReady     = w_accept ? (Requesters'(1) << w_win) : '0;
    assign MemAccess    = w_accept;
    assign MemWrite     = ReqWrite[w_win];
    assign MemAddress   = ReqAddress[w_win*AW +: AW];
    assign MemMask      = ReqMask[w_win*BW +: BW];
    assign MemDToTarget = ReqDToTarget[w_win*DW +: DW];

    assign ReqDataReady    = (r_rd_valid && Reset_n)
                           ? (Requesters'(1) << r_rd_owner) : '0;
    assign ReqDToInitiator = MemDToInitiator;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_last     <= PW'(Requesters - 1);
            r_owner    <= '0;
            r_rd_owner <= '0;
            r_rd_valid <= 1'b0;
            r_locked   <= 1'b0;
            r_idle     <= '0;
        end else begin
            r_rd_valid <= w_accept && !ReqWrite[w_win];
            if (w_accept) begin
                r_last     <= w_win;
                r_rd_owner <= w_win;
                r_locked   <= ReqLock[w_win];
                r_idle     <= '0;
                if (ReqLock[w_win]) begin
                    r_owner <= w_win;
                end
            end else if (w_timeout || !r_locked) begin
                r_locked <= 1'b0;
                r_idle   <= '0;
            end else begin
                r_idle <= r_idle + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_retro_bram_arbiter.sv
// Directed bench for retro_bram_arbiter with a behavioural masked BRAM
// (one-cycle registered read) behind the shared port.
module tb_retro_bram_arbiter;

    localparam int R  = 3;
    localparam int AW = 12;
    localparam int BW = 2;
    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic [R-1:0]  req_access;
    logic [R-1:0]  req_write;
    logic [R-1:0]  req_lock;
    logic [R*AW-1:0] req_addr;
    logic [R*BW-1:0] req_mask;
    logic [R*DW-1:0] req_data;
    logic [R-1:0]  req_ready;
    logic [R-1:0]  req_dready;
    logic [DW-1:0] req_rdata;
    logic          mem_access;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_mask;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    logic [DW-1:0] mem [0:4095];

    int checks;
    int errors;

    retro_bram_arbiter #(
        .Requesters(R),
        .AddressBusWidth(AW),
        .DataBusWidth(BW),
        .LockTimeout(4)
    ) dut (
        .Clk(clk),
        .Reset_n(rst_n),
        .ReqAccess(req_access),
        .ReqWrite(req_write),
        .ReqLock(req_lock),
        .ReqAddress(req_addr),
        .ReqMask(req_mask),
        .ReqDToTarget(req_data),
        .ReqReady(req_ready),
        .ReqDataReady(req_dready),
        .ReqDToInitiator(req_rdata),
        .MemAccess(mem_access),
        .MemWrite(mem_write),
        .MemAddress(mem_addr),
        .MemMask(mem_mask),
        .MemDToTarget(mem_wdata),
        .MemDToInitiator(mem_rdata),
        .MemReady(mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_access) begin
            if (mem_write) begin
                for (int b = 0; b < BW; b++) begin
                    if (mem_mask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic acc, input logic wr, input logic lk,
                           input logic [AW-1:0] a, input logic [BW-1:0] m,
                           input logic [DW-1:0] d);
        req_access[i]       = acc;
        req_write[i]        = wr;
        req_lock[i]         = lk;
        req_addr[i*AW +: AW] = a;
        req_mask[i*BW +: BW] = m;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic clear_all();
        for (int i = 0; i < R; i++) set_req(i, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = '0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[12'h010] = 16'h00A1;
        mem[12'h020] = 16'h00A2;
        mem[12'h030] = 16'h00A3;
        mem[12'h005] = 16'h1234;
        mem[12'h040] = 16'h0077;
        clear_all();

        // Reset holds every strobe low even with requests pending
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 1'b0, 12'h010, 2'b11, 16'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 12'h020, 2'b11, 16'h0);
        set_req(2, 1'b1, 1'b0, 1'b0, 12'h030, 2'b11, 16'h0);
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_dready", 32'(req_dready), 32'h0);
        chk("rst_memaccess", 32'(mem_access), 32'h0);

        // Contention: 0,1,2,0 with one-cycle tagged returns
        @(negedge clk); rst_n = 1'b1; #1;
        chk("c1_ready", 32'(req_ready), 32'h1);
        chk("c1_addr", 32'(mem_addr), 32'h010);
        chk("c1_dready", 32'(req_dready), 32'h0);
        @(negedge clk); #1;
        chk("c2_ready", 32'(req_ready), 32'h2);
        chk("c2_dready", 32'(req_dready), 32'h1);
        chk("c2_data", 32'(req_rdata), 32'h00A1);
        @(negedge clk); #1;
        chk("c3_ready", 32'(req_ready), 32'h4);
        chk("c3_dready", 32'(req_dready), 32'h2);
        chk("c3_data", 32'(req_rdata), 32'h00A2);
        @(negedge clk); #1;
        chk("c4_ready", 32'(req_ready), 32'h1);
        chk("c4_dready", 32'(req_dready), 32'h4);
        chk("c4_data", 32'(req_rdata), 32'h00A3);
        @(negedge clk); clear_all(); #1;
        chk("c5_ready", 32'(req_ready), 32'h0);
        chk("c5_memaccess", 32'(mem_access), 32'h0);
        chk("c5_dready", 32'(req_dready), 32'h1);
        chk("c5_data", 32'(req_rdata), 32'h00A1);

        // Masked write then read back
        @(negedge clk);
        set_req(1, 1'b1, 1'b1, 1'b0, 12'h005, 2'b10, 16'hBEEF);
        #1;
        chk("wr_ready", 32'(req_ready), 32'h2);
        chk("wr_memwrite", 32'(mem_write), 32'h1);
        chk("wr_mask", 32'(mem_mask), 32'h2);
        chk("wr_data", 32'(mem_wdata), 32'hBEEF);
        @(negedge clk); clear_all();
        set_req(2, 1'b1, 1'b0, 1'b0, 12'h005, 2'b11, 16'h0);
        #1;
        chk("rd5_ready", 32'(req_ready), 32'h4);
        chk("wr_no_dready", 32'(req_dready), 32'h0);
        @(negedge clk); clear_all(); #1;
        chk("rd5_dready", 32'(req_dready), 32'h4);
        chk("rd5_data", 32'(req_rdata), 32'hBE34);

        // Lock hold and release by owner's unlocked write
        @(negedge clk);
        set_req(2, 1'b1, 1'b0, 1'b1, 12'h040, 2'b11, 16'h0);
        #1;
        chk("lk_acq_ready", 32'(req_ready), 32'h4);
        @(negedge clk); clear_all();
        set_req(0, 1'b1, 1'b0, 1'b0, 12'h010, 2'b11, 16'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 12'h020, 2'b11, 16'h0);
        #1;
        chk("lk_hold1_ready", 32'(req_ready), 32'h0);
        chk("lk_dready", 32'(req_dready), 32'h4);
        chk("lk_data", 32'(req_rdata), 32'h0077);
        @(negedge clk); #1;
        chk("lk_hold2_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        set_req(2, 1'b1, 1'b1, 1'b0, 12'h041, 2'b11, 16'h5555);
        #1;
        chk("lk_rel_ready", 32'(req_ready), 32'h4);
        @(negedge clk);
        set_req(2, 1'b0, 1'b0, 1'b0, 12'h0, 2'b00, 16'h0);
        #1;
        chk("lk_after_ready", 32'(req_ready), 32'h1);
        @(negedge clk); clear_all(); #1;
        chk("lk_after_dready", 32'(req_dready), 32'h1);

        // Lock timeout after 4 idle cycles
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 1'b1, 12'h020, 2'b11, 16'h0);
        #1;
        chk("to_acq_ready", 32'(req_ready), 32'h2);
        @(negedge clk); clear_all();
        set_req(0, 1'b1, 1'b0, 1'b0, 12'h010, 2'b11, 16'h0);
        #1;
        chk("to_idle1_ready", 32'(req_ready), 32'h0);
        for (int n = 2; n <= 4; n++) begin
            @(negedge clk); #1;
            chk($sformatf("to_idle%0d_ready", n), 32'(req_ready), 32'h0);
        end
        @(negedge clk); #1;
        chk("to_release_ready", 32'(req_ready), 32'h1);
        @(negedge clk); clear_all(); #1;
        chk("to_dready", 32'(req_dready), 32'h1);

        // MemReady stall keeps the pointer where it was
        @(negedge clk);
        mem_ready = 1'b0;
        set_req(1, 1'b1, 1'b0, 1'b0, 12'h020, 2'b11, 16'h0);
        set_req(2, 1'b1, 1'b0, 1'b0, 12'h030, 2'b11, 16'h0);
        #1;
        for (int n = 1; n <= 3; n++) begin
            if (n > 1) begin
                @(negedge clk); #1;
            end
            chk($sformatf("st%0d_ready", n), 32'(req_ready), 32'h0);
            chk($sformatf("st%0d_memaccess", n), 32'(mem_access), 32'h0);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        set_req(1, 1'b1, 1'b0, 1'b1, 12'h020, 2'b11, 16'h0);
        #1;
        chk("st_resume_ready", 32'(req_ready), 32'h2);

        // Reset right after a locked read is accepted
        @(negedge clk); rst_n = 1'b0; #1;
        chk("mr_dready", 32'(req_dready), 32'h0);
        chk("mr_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b1, 1'b0, 1'b0, 12'h010, 2'b11, 16'h0);
        #1;
        chk("mr_first_ready", 32'(req_ready), 32'h1);
        chk("mr_post_dready", 32'(req_dready), 32'h0);

        @(negedge clk); clear_all();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/retro_bram_arbiter.md
# retro_bram_arbiter

Round-robin arbiter that shares one single-port RetroBRAM target among `Requesters` initiators, for example CPU, DMA and video fetch contending for system RAM or VRAM. It selects one pending request per cycle and muxes that request onto the BRAM port. It routes the one-cycle-latency read data back, tagged to the requester that issued it. An optional per-requester lock holds the port for read-modify-write sequences, and a timeout guarantees the lock is eventually released.

## Interface
Parameters:
- `Requesters`, 3: number of initiators, 2..8.
- `AddressBusWidth`, 12: word address width, matching the BRAM.
- `DataBusWidth`, 1: data width in bytes; data is 8×`DataBusWidth` bits.
- `LockTimeout`, 16: idle cycles after which a held lock is force-released, ≥1.

Ports:
- `Clk`  in  1  sole clock; all state changes on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `ReqAccess`  in  Requesters  per-requester request; held until accepted.
- `ReqWrite`  in  Requesters  1 = write, 0 = read.
- `ReqLock`  in  Requesters  request or keep the lock with this access.
- `ReqAddress`  in  Requesters×AddressBusWidth  packed; requester i occupies slice i.
- `ReqMask`  in  Requesters×DataBusWidth  byte write enables, packed.
- `ReqDToTarget`  in  Requesters×8·DataBusWidth  write data, packed.
- `ReqReady`  out  Requesters  one-hot-or-zero; high means the access is accepted at this edge.
- `ReqDataReady`  out  Requesters  one-hot-or-zero; read data is valid this cycle.
- `ReqDToInitiator`  out  8·DataBusWidth  read data, broadcast to all requesters; qualify with `ReqDataReady`.
- `MemAccess`, `MemWrite`  out  1 each  to the BRAM.
- `MemAddress`  out  AddressBusWidth  to the BRAM.
- `MemMask`  out  DataBusWidth  to the BRAM.
- `MemDToTarget`  out  8·DataBusWidth  to the BRAM.
- `MemDToInitiator`  in  8·DataBusWidth  BRAM registered read data.
- `MemReady`  in  1  BRAM ready; the BRAM ties this to 1.

## Operation
- **Arbitration (combinational).** Among the requesters with `ReqAccess` high, the winner is the first in round-robin order starting at `LastGrant+1`, wrapping modulo `Requesters`.
- **Winner path.** The winner's fields drive the `Mem*` outputs and `ReqReady[winner]`=`MemReady`.
- **No winner or `MemReady`=0.** `MemAccess`=0, all `ReqReady`=0, and other `Mem*` outputs are don't-care.
- **Acceptance edge.** An access is accepted when `ReqReady[i]`=1 at the edge. On that edge, `LastGrant`←i.
- **Read return.** An accepted read sets `RdValid`←1 and `RdOwner`←i. Any other edge sets `RdValid`←0.
  - `ReqDataReady[k]` = `RdValid` && `RdOwner`==k.
  - `ReqDToInitiator` = `MemDToInitiator`, passed straight through.
- **Lock acquire and hold.**
  - An accepted access with `ReqLock[i]`=1 sets `Locked`←1 and `LockOwner`←i.
  - While `Locked`, only `LockOwner` is eligible and all other requests stall.
- **Lock release.** Whichever of these happens first:
  - `LockOwner` has an accepted access with `ReqLock`=0. That access still completes.
  - `IdleCnt` reaches `LockTimeout`.
- **Idle counter.**
  - Clears on every accepted owner access and whenever the port is unlocked.
  - Otherwise increments, saturating, while `Locked`.
- **Writes.** Complete in the acceptance cycle and produce no `ReqDataReady`.
- **Width rule.** Pointers and owners are `$clog2(Requesters)` bits. The counter is `$clog2(LockTimeout+1)` bits.

## Timing
- **Reset values.**
  - `LastGrant`=Requesters−1, so requester 0 wins first.
  - `RdValid`=0, `Locked`=0, `IdleCnt`=0.
  - All `ReqReady`, `ReqDataReady` and `MemAccess` read 0 while `Reset_n`=0, regardless of other inputs.
- **Grant latency.** Zero cycles: a request asserted in cycle T with no contention is accepted at the end of T.
- **Read latency.** Accepted at edge T, so `ReqDataReady` is high and data is valid throughout cycle T+1, for exactly one cycle.
- **Throughput.** One access per cycle. Back-to-back reads from different requesters each return on the following cycle with the correct owner.
- **Fairness.** Without locks, a continuously requesting requester waits at most `Requesters`−1 cycles.
- **Simultaneous events.**
  - A timeout and an owner request in the same cycle: the request wins, is accepted, and the counter clears.
  - A release access and a new lock request from the same owner: impossible by construction, because one `ReqLock` bit is sampled.
- **Reset mid-operation.** A pending read return is discarded, `ReqDataReady` stays 0, and the lock is dropped.

## Test plan
- **Reset then contention.** Reset, then requesters 0, 1 and 2 all hold reads to addresses 0x010, 0x020 and 0x030. Required: grants in order 0, 1, 2, 0. Each `ReqDataReady` fires one cycle after its grant, carrying the preloaded data 0xA1, 0xA2, 0xA3.
- **Masked write, then read.** Requester 1 writes 0xBEEF to 0x005 with `DataBusWidth`=2 and Mask=2'b10. Then requester 2 reads 0x005, which previously held 0x1234. Required: read returns 0xBE34, `ReqDataReady`=3'b100, and no `ReqDataReady` for the write.
- **Lock hold and release.** Requester 2 accepts a locked read of 0x040 while 0 and 1 request continuously. Required: 0 and 1 get no `ReqReady` until requester 2's unlocked write is accepted. Then requester 0 is granted on the next cycle.
- **Lock timeout.** With `LockTimeout`=4, requester 1 locks and then idles. Required: requester 0 stalls, the lock releases after 4 idle cycles, and requester 0 is granted in the 5th.
- **`MemReady` stall.** Force `MemReady`=0 for 3 cycles with requests pending. Required: no `ReqReady`, `MemAccess`=0, and `LastGrant` is unchanged. Arbitration resumes at the same requester.
- **Mid-read reset.** Pulse `Reset_n` low for 1 cycle immediately after a read is accepted. Required: no `ReqDataReady`, `Locked`=0, and requester 0 wins first after release.
